matvec_lanes: RTL
=================

// Module: matvec_lanes
// PURPOSE
//  Streaming matrix-vector multiplier, next generation of the single-lane matmul engine. Matrix
//  arrives row-major as LANES-wide beats; the vector sits in an external SRAM, one word =
//  LANES elements. Emits one ACC_W dot product per row, with full ready/valid backpressure,
//  signed/unsigned mode, start/done control and masking of ragged row tails.
// PARAMETERS
//  LANES            4   elements per input beat and per SRAM word (power of 2, >=1)
//  DATA_W           8   matrix/vector element width
//  ACC_W            32  accumulator and result width (>= 2*DATA_W+clog2(MAX_DIM))
//  MAX_DIM          256 max hdim/vdim supported
//  SRAM_ADDR_WIDTH  10  vector SRAM word-address width
// PORTS
//  clk            in   1                clock, all logic on rising edge
//  rst_n          in   1                synchronous active-low reset
//  start          in   1                begin a job (sampled in IDLE only)
//  signed_mode    in   1                1: two's-complement operands; 0: unsigned (latched at start)
//  vdim           in   8                rows (latched at start)
//  hdim           in   8                columns (latched at start)
//  busy           out  1                high from accepted start until done pulse
//  done           out  1                one-cycle pulse after final result accepted
//  in_data        in   LANES*DATA_W     matrix beat, lane 0 in LSBs = lowest column
//  in_valid       in   1                beat valid
//  in_ready       out  1                beat accepted when in_valid&&in_ready
//  out_data       out  ACC_W            row dot product
//  out_valid      out  1                result valid; held with data stable until out_ready
//  out_ready      in   1                downstream accept
//  out_last       out  1                qualifies out_valid: final row of job
//  vec_sram_re    out  1                SRAM read enable
//  vec_sram_addr  out  SRAM_ADDR_WIDTH  word address = beat index within row
//  vec_sram_dout  in   LANES*DATA_W     read data, 1-cycle latency; holds value while re=0
// BEHAVIOUR
//  Reset: busy=0 done=0 in_ready=0 out_valid=0 out_last=0 out_data=0 vec_sram_re=0 addr=0;
//   FSM=IDLE, accumulator, counters and all stage valids cleared. Reset mid-job discards all
//   in-flight data; no partial result is emitted.
//  FSM: IDLE -start-> RUN (dims, mode latched; busy=1). If vdim==0 or hdim==0: IDLE -> DONE
//   directly, no beats consumed, no outputs. RUN -> DRAIN when last beat of last row accepted
//   (in_ready drops next cycle). DRAIN -> DONE when last result handshaken. DONE: done=1,
//   busy=0 for one cycle -> IDLE. start outside IDLE is ignored.
//  Beats per row NB = ceil(hdim/LANES); last beat lanes with column >= hdim masked to zero
//   product (in_data and SRAM contents there are don't-care).
//  Pipeline, global advance adv = !out_valid || out_ready:
//   S0 accept: in_ready = (FSM==RUN) && adv; on accept issue re=1, addr=beat idx, register beat.
//   S1 wait: SRAM latency; data captured at S1->S2 edge. vec_sram_re=0 whenever !adv.
//   S2 MAC: LANES products (sign- or zero-extended per latched mode) summed by adder tree.
//   S3 acc: acc += tree sum; on row's last beat out_data = acc+sum, out_valid=1, acc=0.
//  Latency: last beat of row accepted at cycle t -> out_valid at t+3 (no stall).
//  Throughput: 1 beat/cycle sustained while out_ready=1; stalls freeze every stage, no loss.
//  Arithmetic: products 2*DATA_W, extended to ACC_W, sums wrap modulo 2^ACC_W, no saturation.
//  Simultaneous out handshake and new result in same cycle: new result loads, no bubble.
//  Row/beat counters wrap to 0 at row end; SRAM addr restarts at 0 each row.
// STRUCTURE
//  Package matvec_pkg: FSM state enum {IDLE,RUN,DRAIN,DONE}, localparams for lane index
//   width, beat-count width, product width; helper function for lane mask from hdim.
//  Sub-module matvec_lane_mac: LANES multipliers + mask + pipelined-free adder tree (S2 logic),
//   parameterised by LANES/DATA_W/ACC_W with signed_mode input.
//  Top holds FSM, counters, handshake, S0/S1/S3 registers.
// TESTING
//  1 LANES=4 unsigned, vdim=2 hdim=8, vec=1..8, rows all 1 and all 2 -> out 36 then 72,
//    out_last on second, done pulse once.
//  2 Ragged: hdim=5, vec=1..8 in SRAM, row all 1 -> out 15 (lanes 5-7 masked).
//  3 Signed: hdim=4, row {-1,-2,3,4}, vec {2,2,2,-1} -> out -4 (0xFFFFFFFC); unsigned
//    mode same bits -> 255*2+254*2+3*2+4*255 = 2044.
//  4 Backpressure: out_ready low 20 cycles mid-job, random in_valid -> results equal
//    golden model, out_data stable while held, no beat lost/duplicated.
//  5 vdim=0 -> done one cycle after IDLE->DONE, no in_ready, no out_valid.
//  6 rst_n low mid-row then fresh job -> only new job's results appear, acc starts at 0.

Source files
------------

// File: rtl/matvec_pkg.sv
// Shared types, widths and the ragged-tail lane mask helper for the
// multi-lane matrix-vector engine.
package matvec_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam int LANES_DEF  = 4;
  localparam int DATA_W_DEF = 8;
  localparam int DIM_W      = 8;
  localparam int BEAT_W     = DIM_W;
  localparam int LANE_IDX_W = (LANES_DEF > 1) ? $clog2(LANES_DEF) : 1;
  localparam int PROD_W     = 2 * DATA_W_DEF;

  // A lane carries a real column only while its column index is below hdim.
  function automatic logic lane_active(input logic [DIM_W-1:0]  hdim,
                                       input logic [BEAT_W-1:0] beat,
                                       input int                lane,
                                       input int                lanes);
    return ((int'(beat) * lanes) + lane) < int'(hdim);
  endfunction

endpackage

// File: rtl/matvec_lane_mac.sv
// One beat worth of lane products, masked and reduced by a combinational
// adder tree; operands are sign- or zero-extended by signed_mode_i.
module matvec_lane_mac
  import matvec_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                    signed_mode_i,
  input  logic [LANES*DATA_W-1:0] mat_i,
  input  logic [LANES*DATA_W-1:0] vec_i,
  input  logic [LANES-1:0]        mask_i,
  output logic [ACC_W-1:0]        sum_o
);

  localparam int PW = 2 * DATA_W + 2;

  logic [ACC_W-1:0] node [1:2*LANES-1];

  // Leaves live at LANES..2*LANES-1, node k sums children 2k and 2k+1.
  always_comb begin
    logic signed [DATA_W:0] a;
    logic signed [DATA_W:0] b;
    logic signed [PW-1:0]   p;
    for (int k = 1; k < 2 * LANES; k++) node[k] = '0;
    for (int i = 0; i < LANES; i++) begin
      a = {signed_mode_i & mat_i[i*DATA_W+DATA_W-1], mat_i[i*DATA_W +: DATA_W]};
      b = {signed_mode_i & vec_i[i*DATA_W+DATA_W-1], vec_i[i*DATA_W +: DATA_W]};
      p = PW'(a) * PW'(b);
      node[LANES+i] = mask_i[i] ? ACC_W'(p) : '0;
    end
    for (int k = LANES - 1; k >= 1; k--) node[k] = node[2*k] + node[2*k+1];
    sum_o = node[1];
  end

endmodule

// File: rtl/matvec_lanes.sv
// Streaming matrix-vector multiplier: row-major LANES-wide matrix beats against
// an SRAM-resident vector, one wrapped ACC_W dot product per row.
module matvec_lanes
  import matvec_pkg::*;
#(
  parameter int LANES           = 4,
  parameter int DATA_W          = 8,
  parameter int ACC_W           = 32,
  parameter int MAX_DIM         = 256,
  parameter int SRAM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic [DIM_W-1:0]           vdim,
  input  logic [DIM_W-1:0]           hdim,
  output logic                       busy,
  output logic                       done,
  input  logic [LANES*DATA_W-1:0]    in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [ACC_W-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       vec_sram_re,
  output logic [SRAM_ADDR_WIDTH-1:0] vec_sram_addr,
  input  logic [LANES*DATA_W-1:0]    vec_sram_dout
);

  localparam int BW    = LANES * DATA_W;
  localparam int CNT_W = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int LSH   = $clog2(LANES);

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  vdim_q, hdim_q;
  logic              mode_q;
  logic [BEAT_W-1:0] nb_q, beat_q;
  logic [CNT_W-1:0]  row_q;
  logic [DIM_W:0]    nb_calc;
  logic              adv, accept, last_beat, last_row;
  logic [LANES-1:0]  beat_mask;

  logic              s1_valid_q, s1_lb_q, s1_lr_q;
  logic [BW-1:0]     s1_data_q;
  logic [LANES-1:0]  s1_mask_q;
  logic              s2_valid_q, s2_lb_q, s2_lr_q;
  logic [BW-1:0]     s2_mat_q, s2_vec_q;
  logic [LANES-1:0]  s2_mask_q;
  logic [ACC_W-1:0]  acc_q, out_data_q, mac_sum;
  logic              out_valid_q, out_last_q;

  // Every stage moves together whenever the output register can take a new value.
  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = (state_q == RUN) && adv;
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_q == nb_q - BEAT_W'(1));
  assign last_row  = (row_q == CNT_W'(vdim_q - DIM_W'(1)));
  assign nb_calc   = ({1'b0, hdim} + (DIM_W+1)'(LANES - 1)) >> LSH;

  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign vec_sram_re   = accept;
  assign vec_sram_addr = SRAM_ADDR_WIDTH'(beat_q);
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_last      = out_last_q;

  always_comb begin
    beat_mask = '0;
    for (int i = 0; i < LANES; i++) beat_mask[i] = lane_active(hdim_q, beat_q, i, LANES);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (vdim == '0 || hdim == '0) ? DONE : RUN;
      RUN:     if (accept && last_beat && last_row) state_d = DRAIN;
      DRAIN:   if (out_valid_q && out_ready && out_last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vdim_q <= '0;
      hdim_q <= '0;
      mode_q <= 1'b0;
      nb_q   <= '0;
      beat_q <= '0;
      row_q  <= '0;
    end else if (state_q == IDLE && start) begin
      vdim_q <= vdim;
      hdim_q <= hdim;
      mode_q <= signed_mode;
      nb_q   <= BEAT_W'(nb_calc);
      beat_q <= '0;
      row_q  <= '0;
    end else if (accept) begin
      if (last_beat) begin
        beat_q <= '0;
        row_q  <= last_row ? '0 : row_q + CNT_W'(1);
      end else begin
        beat_q <= beat_q + BEAT_W'(1);
      end
    end
  end

  matvec_lane_mac #(
    .LANES (LANES),
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .signed_mode_i(mode_q),
    .mat_i        (s2_mat_q),
    .vec_i        (s2_vec_q),
    .mask_i       (s2_mask_q),
    .sum_o        (mac_sum)
  );

  // SRAM read data lands one cycle after the request and is taken on the S1->S2 move.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_lb_q     <= 1'b0;
      s1_lr_q     <= 1'b0;
      s1_data_q   <= '0;
      s1_mask_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_lb_q     <= 1'b0;
      s2_lr_q     <= 1'b0;
      s2_mat_q    <= '0;
      s2_vec_q    <= '0;
      s2_mask_q   <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (adv) begin
      s1_valid_q  <= accept;
      s1_lb_q     <= accept && last_beat;
      s1_lr_q     <= accept && last_beat && last_row;
      s1_data_q   <= in_data;
      s1_mask_q   <= beat_mask;
      s2_valid_q  <= s1_valid_q;
      s2_lb_q     <= s1_lb_q;
      s2_lr_q     <= s1_lr_q;
      s2_mat_q    <= s1_data_q;
      s2_vec_q    <= vec_sram_dout;
      s2_mask_q   <= s1_mask_q;
      out_valid_q <= s2_valid_q && s2_lb_q;
      out_last_q  <= s2_valid_q && s2_lb_q && s2_lr_q;
      if (s2_valid_q) begin
        if (s2_lb_q) begin
          out_data_q <= acc_q + mac_sum;
          acc_q      <= '0;
        end else begin
          acc_q <= acc_q + mac_sum;
        end
      end
    end
  end

endmodule
